// File: rtl/ariane_pkg.sv
// ariane_pkg: RoCC command/response types and dispatcher defaults shared across the core
package ariane_pkg;
  localparam int ROCC_NR_ACCEL = 4;
  localparam int ROCC_MAX_OUTSTANDING = 4;
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic       xd;
    logic       xs1;
    logic       xs2;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rocc_instr_t;
  typedef struct packed {
    rocc_instr_t instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } rocc_cmd_t;
  typedef struct packed {
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
  } rocc_resp_t;
endpackage

// File: rtl/rocc_dispatcher_if.sv
// rocc_dispatcher_if: core-side and accelerator-side RoCC handshakes around the dispatcher
interface rocc_dispatcher_if
  import ariane_pkg::*;
#(parameter int NR_ACCEL = ROCC_NR_ACCEL);
  rocc_cmd_t                 cmd_i;
  logic                      cmd_valid_i, cmd_ready_o;
  rocc_cmd_t  [NR_ACCEL-1:0] accel_cmd_o;
  logic       [NR_ACCEL-1:0] accel_cmd_valid_o, accel_cmd_ready_i;
  rocc_resp_t [NR_ACCEL-1:0] accel_resp_i;
  logic       [NR_ACCEL-1:0] accel_resp_valid_i, accel_resp_ready_o;
  rocc_resp_t                resp_o;
  logic                      resp_valid_o, resp_ready_i, busy_o;
  modport slave (
    input  cmd_i, cmd_valid_i, accel_cmd_ready_i, accel_resp_i, accel_resp_valid_i, resp_ready_i,
    output cmd_ready_o, accel_cmd_o, accel_cmd_valid_o, accel_resp_ready_o, resp_o, resp_valid_o, busy_o
  );
  modport master (
    output cmd_i, cmd_valid_i, accel_cmd_ready_i, accel_resp_i, accel_resp_valid_i, resp_ready_i,
    input  cmd_ready_o, accel_cmd_o, accel_cmd_valid_o, accel_resp_ready_o, resp_o, resp_valid_o, busy_o
  );
endinterface

// File: rtl/rocc_rr_arb.sv
// rocc_rr_arb: N-way round-robin one-hot arbiter; pointer moves past the winner on each grant
module rocc_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] ptr, idx;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && req[IW'(ptr + IW'(k))]) begin
        found = 1'b1;
        idx = IW'(ptr + IW'(k));
      end
    end
    if (found) gnt[idx] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr <= '0;
    else if (found) ptr <= IW'(idx + 1'b1);
endmodule

// File: rtl/rocc_dispatcher.sv
// rocc_dispatcher: routes RoCC commands to NR_ACCEL accelerators and merges their responses.
// Define ROCC_DISPATCH_RD_CHECK_EN to add a pending-rd scoreboard that stalls WAW hazards.
module rocc_dispatcher
  import ariane_pkg::*;
#(
  parameter int NR_ACCEL        = ROCC_NR_ACCEL,
  parameter int MAX_OUTSTANDING = ROCC_MAX_OUTSTANDING
) (
  input logic             clk_i,
  input logic             rst_ni,
  rocc_dispatcher_if.slave bus
);
  localparam int IW = $clog2(NR_ACCEL);
  logic [IW-1:0] tgt;
  logic xd, stall, cmd_fire, drain_ok, any_cnt;
  logic [3:0] cnt [NR_ACCEL];
  logic [NR_ACCEL-1:0] inc, gnt;
  rocc_resp_t resp_sel;
  assign tgt = bus.cmd_i.instr.funct7[IW-1:0];
  assign xd  = bus.cmd_i.instr.xd;
`ifdef ROCC_DISPATCH_RD_CHECK_EN
  logic [31:0] sb, sb_set, sb_clr;
  assign stall  = xd & ((cnt[tgt] == 4'(MAX_OUTSTANDING)) | sb[bus.cmd_i.instr.rd]);
  assign sb_set = (cmd_fire && xd) ? 32'(1) << bus.cmd_i.instr.rd : '0;
  assign sb_clr = (|gnt) ? 32'(1) << resp_sel.resp_rd : '0;
  // a new claim on an rd wins over a same-cycle release of it
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sb <= '0;
    else sb <= (sb & ~sb_clr) | sb_set;
`else
  assign stall = xd & (cnt[tgt] == 4'(MAX_OUTSTANDING));
`endif
  assign bus.cmd_ready_o = bus.accel_cmd_ready_i[tgt] & ~stall;
  assign bus.accel_cmd_o = {NR_ACCEL{bus.cmd_i}};
  assign cmd_fire        = bus.cmd_valid_i & bus.cmd_ready_o;
  assign inc             = (cmd_fire && xd) ? NR_ACCEL'(1) << tgt : '0;
  always_comb begin
    bus.accel_cmd_valid_o = '0;
    bus.accel_cmd_valid_o[tgt] = bus.cmd_valid_i & ~stall;
  end
  assign drain_ok = ~bus.resp_valid_o | bus.resp_ready_i;
  rocc_rr_arb #(.N(NR_ACCEL)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (bus.accel_resp_valid_i),
    .en     (drain_ok),
    .gnt    (gnt)
  );
  assign bus.accel_resp_ready_o = gnt;
  always_comb begin
    resp_sel = '0;
    for (int i = 0; i < NR_ACCEL; i++) if (gnt[i]) resp_sel = bus.accel_resp_i[i];
  end
  // unsolicited responses still drain; the counter just stays at zero
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < NR_ACCEL; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NR_ACCEL; i++)
        if (inc[i] && !gnt[i]) cnt[i] <= cnt[i] + 4'd1;
        else if (gnt[i] && !inc[i] && cnt[i] != 4'd0) cnt[i] <= cnt[i] - 4'd1;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bus.resp_o <= '0;
      bus.resp_valid_o <= 1'b0;
    end else if (|gnt) begin
      bus.resp_o <= resp_sel;
      bus.resp_valid_o <= 1'b1;
    end else if (bus.resp_ready_i) begin
      bus.resp_valid_o <= 1'b0;
    end
  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < NR_ACCEL; i++) any_cnt = any_cnt | (|cnt[i]);
  end
  assign bus.busy_o = any_cnt | bus.resp_valid_o;
endmodule

// File: tb/tb_rocc_dispatcher.sv
// tb_rocc_dispatcher: directed scenarios plus random traffic checked every cycle against a queue-free behavioural model
module tb_rocc_dispatcher;
  import ariane_pkg::*;
  localparam int N = 4;
  localparam int MAXO = 4;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;
  rocc_dispatcher_if #(.NR_ACCEL(N)) bus ();
  rocc_dispatcher #(.NR_ACCEL(N), .MAX_OUTSTANDING(MAXO)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // behavioural model: outstanding counts, rr pointer, output slot, pending-rd set
  int m_cnt [N];
  int n_cnt [N];
  int m_ptr, n_ptr;
  bit m_ov, n_ov;
  rocc_resp_t m_out, n_out;
  logic [31:0] m_sb, n_sb;
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0;
    m_ov = 0;
    m_out = '0;
    m_sb = '0;
  endtask
  initial begin
    int tgt, g, e_cv, e_arr;
    bit stall, e_cr, e_busy, fire;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_ni) model_reset();
      tgt = int'(bus.cmd_i.instr.funct7) % N;
      stall = bus.cmd_i.instr.xd && (m_cnt[tgt] == MAXO);
`ifdef ROCC_DISPATCH_RD_CHECK_EN
      stall = stall || (bus.cmd_i.instr.xd && m_sb[bus.cmd_i.instr.rd]);
`endif
      e_cv = (bus.cmd_valid_i && !stall) ? (1 << tgt) : 0;
      e_cr = bus.accel_cmd_ready_i[tgt] && !stall;
      g = -1;
      if (!m_ov || bus.resp_ready_i)
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.accel_resp_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_arr = (g >= 0) ? (1 << g) : 0;
      e_busy = m_ov;
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) e_busy = 1;
      chk("m_accel_cmd_valid", 256'(bus.accel_cmd_valid_o), 256'(e_cv));
      chk("m_cmd_ready", 256'(bus.cmd_ready_o), 256'(e_cr));
      chk("m_accel_resp_ready", 256'(bus.accel_resp_ready_o), 256'(e_arr));
      chk("m_resp_valid", 256'(bus.resp_valid_o), 256'(m_ov));
      chk("m_busy", 256'(bus.busy_o), 256'(e_busy));
      if (m_ov) chk("m_resp_o", 256'(bus.resp_o), 256'(m_out));
      for (int i = 0; i < N; i++) chk("m_cmd_bcast", 256'(bus.accel_cmd_o[i]), 256'(bus.cmd_i));
      fire = bus.cmd_valid_i && e_cr;
      for (int i = 0; i < N; i++) begin
        n_cnt[i] = m_cnt[i] + ((fire && bus.cmd_i.instr.xd && i == tgt) ? 1 : 0) - ((i == g) ? 1 : 0);
        if (n_cnt[i] < 0) n_cnt[i] = 0;
      end
      n_sb = m_sb;
      if (g >= 0) n_sb[bus.accel_resp_i[g].resp_rd] = 1'b0;
      if (fire && bus.cmd_i.instr.xd) n_sb[bus.cmd_i.instr.rd] = 1'b1;
      n_ptr = (g >= 0) ? (g + 1) % N : m_ptr;
      n_ov = (g >= 0) ? 1'b1 : (bus.resp_ready_i ? 1'b0 : m_ov);
      n_out = (g >= 0) ? bus.accel_resp_i[g] : m_out;
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) model_reset();
      else begin
        m_cnt = n_cnt;
        m_ptr = n_ptr;
        m_ov = n_ov;
        m_out = n_out;
        m_sb = n_sb;
      end
    end
  end
  task automatic drive(input bit cv, input int f7, input bit xd, input int rd,
                       input logic [N-1:0] acr, input logic [N-1:0] arv, input bit rr);
    @(negedge clk);
    bus.cmd_valid_i = cv;
    bus.cmd_i.instr.funct7 = 7'(f7);
    bus.cmd_i.instr.xd = xd;
    bus.cmd_i.instr.rd = 5'(rd);
    bus.accel_cmd_ready_i = acr;
    bus.accel_resp_valid_i = arv;
    bus.resp_ready_i = rr;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, '0, '0, 1);
  endtask
  task automatic default_payloads();
    for (int i = 0; i < N; i++) bus.accel_resp_i[i] = '{resp_data: 64'hA0 + 64'(i), resp_rd: 5'(10 + i)};
  endtask
  initial begin
    bus.cmd_i = '0;
    bus.cmd_i.rs1 = 64'h1234;
    bus.cmd_valid_i = 0;
    bus.accel_cmd_ready_i = '0;
    bus.accel_resp_valid_i = '0;
    bus.resp_ready_i = 0;
    default_payloads();
    drive(1, 1, 0, 0, 4'b0010, 4'b1010, 0);
    #3;
    chk("rst_resp_valid", 256'(bus.resp_valid_o), 256'(0));
    chk("rst_busy", 256'(bus.busy_o), 256'(0));
    chk("rst_resp_o", 256'(bus.resp_o), 256'(0));
    chk("rst_cmd_ready", 256'(bus.cmd_ready_o), 256'(1));
    chk("rst_accel_resp_ready", 256'(bus.accel_resp_ready_o), 256'(4'b0010));
    drive(1, 1, 0, 0, 4'b0000, 4'b0000, 0);
    #3 chk("rst_cmd_ready_low", 256'(bus.cmd_ready_o), 256'(0));
    idle();
    rst_ni = 1;
    drive(1, 2, 1, 12, 4'b0100, 0, 1);
    #3;
    chk("t1_accel_cmd_valid", 256'(bus.accel_cmd_valid_o), 256'(4'b0100));
    chk("t1_cmd_ready", 256'(bus.cmd_ready_o), 256'(1));
    idle();
    #3 chk("t1_busy", 256'(bus.busy_o), 256'(1));
    drive(0, 0, 0, 0, 0, 4'b0100, 1);
    #3 chk("t1_resp_ready", 256'(bus.accel_resp_ready_o), 256'(4'b0100));
    idle();
    #3;
    chk("t1_resp_valid", 256'(bus.resp_valid_o), 256'(1));
    chk("t1_resp_data", 256'(bus.resp_o.resp_data), 256'(64'hA2));
    idle();
    #3 chk("t1_idle_busy", 256'(bus.busy_o), 256'(0));
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 20 + k, 4'b0010, 0, 1);
      #3 chk("t2_accept", 256'(bus.cmd_ready_o), 256'(1));
    end
    drive(1, 1, 1, 24, 4'b0010, 0, 1);
    #3;
    chk("t2_full_ready", 256'(bus.cmd_ready_o), 256'(0));
    chk("t2_full_valid", 256'(bus.accel_cmd_valid_o), 256'(0));
    drive(1, 1, 1, 24, 4'b0010, 4'b0010, 1);
    #3 chk("t2_same_cycle_ready", 256'(bus.cmd_ready_o), 256'(0));
    drive(1, 1, 1, 24, 4'b0010, 0, 1);
    #3 chk("t2_after_resp_ready", 256'(bus.cmd_ready_o), 256'(1));
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 4'b0010, 1);
    idle();
    idle();
    #3 chk("t2_drained_busy", 256'(bus.busy_o), 256'(0));
    idle();
    rst_ni = 0;
    idle();
    rst_ni = 1;
    drive(0, 0, 0, 0, 0, 4'b1001, 1);
    #3 chk("t3_gnt0", 256'(bus.accel_resp_ready_o), 256'(4'b0001));
    drive(0, 0, 0, 0, 0, 4'b1001, 1);
    #3;
    chk("t3_gnt3", 256'(bus.accel_resp_ready_o), 256'(4'b1000));
    chk("t3_rd_a", 256'(bus.resp_o.resp_rd), 256'(10));
    drive(0, 0, 0, 0, 0, 4'b1001, 1);
    #3;
    chk("t3_gnt0b", 256'(bus.accel_resp_ready_o), 256'(4'b0001));
    chk("t3_rd_b", 256'(bus.resp_o.resp_rd), 256'(13));
    drive(0, 0, 0, 0, 0, 4'b1001, 1);
    #3 chk("t3_rd_c", 256'(bus.resp_o.resp_rd), 256'(10));
    idle();
    idle();
    drive(0, 0, 0, 0, 0, 4'b0001, 0);
    bus.accel_resp_i[0] = '{resp_data: 64'hcccccccccccccccc, resp_rd: 5'd7};
    #3 chk("t4_first_gnt", 256'(bus.accel_resp_ready_o), 256'(4'b0001));
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 4'b0001, 0);
      bus.accel_resp_i[0] = '{resp_data: 64'h1111111111111111, resp_rd: 5'd8};
      #3;
      chk("t4_hold_data", 256'(bus.resp_o.resp_data), 256'(64'hcccccccccccccccc));
      chk("t4_hold_ready", 256'(bus.accel_resp_ready_o), 256'(0));
    end
    drive(0, 0, 0, 0, 0, 4'b0001, 1);
    #3;
    chk("t4_drain_data", 256'(bus.resp_o.resp_data), 256'(64'hcccccccccccccccc));
    chk("t4_drain_gnt", 256'(bus.accel_resp_ready_o), 256'(4'b0001));
    idle();
    #3 chk("t4_next_data", 256'(bus.resp_o.resp_data), 256'(64'h1111111111111111));
    default_payloads();
    idle();
    for (int k = 1; k <= 2; k++) drive(1, 0, 1, k, 4'b0001, 0, 1);
    drive(1, 0, 1, 3, 4'b0001, 4'b0100, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("t5_pre_valid", 256'(bus.resp_valid_o), 256'(1));
    chk("t5_pre_busy", 256'(bus.busy_o), 256'(1));
    #1 rst_ni = 0;
    #1;
    chk("t5_rst_valid", 256'(bus.resp_valid_o), 256'(0));
    chk("t5_rst_busy", 256'(bus.busy_o), 256'(0));
    idle();
    rst_ni = 1;
    idle();
    #3 chk("t5_post_busy", 256'(bus.busy_o), 256'(0));
`ifdef ROCC_DISPATCH_RD_CHECK_EN
    drive(1, 0, 1, 9, 4'b0011, 0, 1);
    #3 chk("t6_first", 256'(bus.cmd_ready_o), 256'(1));
    drive(1, 1, 1, 9, 4'b0011, 0, 1);
    #3 chk("t6_stall", 256'(bus.cmd_ready_o), 256'(0));
    drive(1, 1, 1, 9, 4'b0011, 4'b0001, 1);
    bus.accel_resp_i[0].resp_rd = 5'd9;
    #3 chk("t6_stall_on_resp", 256'(bus.cmd_ready_o), 256'(0));
    drive(1, 1, 1, 9, 4'b0011, 0, 1);
    #3 chk("t6_release", 256'(bus.cmd_ready_o), 256'(1));
    default_payloads();
`endif
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 6, int'($urandom_range(0, 127)), $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 7)), N'($urandom), N'($urandom) & N'($urandom), $urandom_range(0, 9) < 7);
      bus.cmd_i.rs2 = {$urandom, $urandom};
      for (int i = 0; i < N; i++)
        bus.accel_resp_i[i] = '{resp_data: {$urandom, $urandom}, resp_rd: 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 299) == 0) begin
        #4 rst_ni = 0;
        @(negedge clk);
        rst_ni = 1;
      end
    end
    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
